// File: rtl/blink_pkg.sv
// Purpose : shared types and default timing for the event blinker.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package blink_pkg;

    // Blinker FSM states; the LED is lit only in ON.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Defaults: 100 ms on, 100 ms minimum off-gap at a 100 MHz clk.
    localparam int unsigned DEF_ON_CYCLES  = 32'd10_000_000;
    localparam int unsigned DEF_OFF_CYCLES = 32'd10_000_000;
    localparam int unsigned DEF_PEND_W     = 32'd4;

endpackage

// File: rtl/blink_timer.sv
// Purpose : loadable down-counter that stops at zero and flags expiry.
// Latency : load takes effect next cycle; expired_o reflects the current count.
// Backpr. : none; load_i always wins over counting.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears the count
//   load_i     load load_val_i into the counter this cycle
//   load_val_i value to load (the counter expires after load_val_i+1 cycles)
//   expired_o  high while the count is zero
module blink_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/event_blinker.sv
// Purpose : turns single-cycle events into fixed-length LED blinks, queueing bursts.
// Latency : evt_in in IDLE with nothing pending lights led_out on the next cycle.
// Backpr. : none; events beyond the pending capacity are dropped and flagged on overflow.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; aborts any blink, clears pending
//   evt_in   single-cycle event pulse, synchronous to clk
//   led_out  registered LED drive, high for ON_CYCLES per accepted event
//   busy     registered, high whenever the FSM is not IDLE
//   pending  registered count of accepted events not yet started (saturating)
//   overflow registered one-cycle pulse when an event was dropped
module event_blinker
    import blink_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int unsigned PEND_W     = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TMR_W      = $clog2(MAX_CYCLES + 1);

    // The timer holds "cycles left minus one", so a phase of N cycles loads N-1
    // and the phase ends on the cycle the timer reads zero.
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    blink_state_t      state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, busy_q, ovf_q, ovf_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    logic eligible;
    logic start;
    logic take_pend;
    logic take_direct;
    logic incr;

    blink_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // A new blink may begin from IDLE or on the final cycle of the off-gap.
    // Queued events are served first; a fresh evt_in only bypasses the queue
    // when it is empty.
    assign eligible    = (state_q == IDLE) || ((state_q == OFF) && tmr_expired);
    assign start       = eligible && ((pend_q != '0) || evt_in);
    assign take_pend   = start && (pend_q != '0);
    assign take_direct = start && (pend_q == '0);
    assign incr        = evt_in && !take_direct;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ovf_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: state_d = IDLE;
            ON: begin
                if (tmr_expired) begin
                    state_d  = OFF;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            OFF: begin
                if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d  = ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
        end

        // Simultaneous enqueue and dequeue leave the count unchanged, which is
        // also what lets an event at full capacity be accepted on a start cycle.
        if (incr && !take_pend) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (take_pend && !incr) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == ON);
            busy_q  <= (state_d != IDLE);
            ovf_q   <= ovf_d;
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_event_blinker.sv
// Purpose : randomized self-checking bench for event_blinker against a timeline model.
// Latency : outputs compared every cycle on the falling edge.
// Backpr. : n/a.
module tb_event_blinker;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          evt_in;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    always #5 clk = ~clk;

    event_blinker #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .PEND_W     (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .evt_in   (evt_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: a blink is described only by the cycle its LED first
    // lights (m_t0); everything else follows from the on/off durations.
    bit m_active = 1'b0;
    int m_t0     = 0;
    int m_pend   = 0;
    bit m_ovf    = 1'b0;
    int m_starts = 0;

    int   obs_starts = 0;
    logic prev_led   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_led();
        return m_active && ((cyc - m_t0) < ON);
    endfunction

    // Advance the model by one clock edge with inputs (e, r) applied at cycle cyc.
    task automatic model_step(input bit e, input bit r);
        bit last, elig, start, from_p, direct;
        int np;
        if (r) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
            return;
        end
        last   = m_active && (cyc == m_t0 + ON + OFF - 1);
        elig   = !m_active || last;
        start  = elig && ((m_pend > 0) || e);
        from_p = start && (m_pend > 0);
        direct = start && (m_pend == 0);
        np     = m_pend - int'(from_p) + int'(e && !direct);
        m_ovf  = 1'b0;
        if (np > PMAX) m_ovf = 1'b1;
        else           m_pend = np;
        if (start) begin
            m_active = 1'b1;
            m_t0     = cyc + 1;
            m_starts++;
        end else if (last) begin
            m_active = 1'b0;
        end
    endtask

    // Called on a falling edge: check this cycle's outputs, apply inputs,
    // advance the model, and move to the next falling edge.
    task automatic step(input bit e, input bit r);
        chk("led_out",  32'(led_out),  32'(m_led()));
        chk("busy",     32'(busy),     32'(m_active));
        chk("pending",  32'(pending),  32'(m_pend));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (led_out === 1'b1 && prev_led !== 1'b1) obs_starts++;
        prev_led = led_out;
        evt_in = e;
        rst    = r;
        model_step(e, r);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulses(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) step(pat[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    int dens_tab[4] = '{2, 4, 10, 30};

    initial begin
        rst    = 1'b1;
        evt_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Events during reset must be ignored; first cycles check reset state.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);   // first cycle after reset accepts evt_in
        idle(12);

        // Single pulse, then a burst of three.
        pulses(16'b1, 1);          idle(12);
        pulses(16'b111, 3);        idle(30);
        // Five back-to-back: saturate at 3, drop the fifth.
        pulses(16'b11111, 5);      idle(40);
        // Fill to 3 pending, then an event exactly on the first off-gap expiry.
        pulses(16'b1000_1111, 8);  idle(45);
        // Event exactly on off-gap expiry with nothing pending.
        pulses(16'b1000_0001, 8);  idle(15);
        // Reset in the middle of ON with two pending, then a fresh event.
        pulses(16'b0111, 4);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        idle(15);

        for (int seg = 0; seg < 16; seg++) begin
            int dens;
            dens = dens_tab[$urandom_range(3)];
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(dens - 1) == 0, $urandom_range(599) == 0);
            end
        end

        idle(20);
        chk("blink_count", 32'(obs_starts), 32'(m_starts));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/event_blinker.md
EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 10000000, LED on-time per event in clk cycles (100 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter OFF_CYCLES, default 10000000, minimum LED off-gap after each blink in clk cycles; legal range >= 1.
REQ-003 SHALL have parameter PEND_W, default 4, width of the pending-event counter (max pending = 2^PEND_W-1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port evt_in  input  1  single-cycle event pulse, already synchronous to clk.
REQ-007 SHALL have port led_out  output  1  registered LED drive, high during a blink.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port pending  output  PEND_W  count of accepted events not yet started.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, ON, OFF; led_out=1 only in ON.
REQ-012 SHALL define "start" in a cycle as: (state IDLE, or state OFF with timer expired) and (pending>0 or evt_in=1).
REQ-013 On start, SHALL enter ON next cycle with timer loaded; one event consumed: from pending if pending>0, else evt_in directly.
REQ-014 Latency: evt_in at cycle N in IDLE with pending=0 SHALL give led_out=1 at cycle N+1, pending stays 0.
REQ-015 SHALL hold ON for exactly ON_CYCLES cycles, then enter OFF.
REQ-016 SHALL hold OFF for exactly OFF_CYCLES cycles; at expiry, start (REQ-013) if eligible, else IDLE.
REQ-017 Pending update per cycle: +1 if evt_in not consumed directly, -1 if consumed from pending; both -> unchanged.
REQ-018 evt_in while pending=max and no consumption that cycle SHALL be dropped, pending unchanged, overflow=1 next cycle only.
REQ-019 evt_in while pending=max and a consumption that cycle SHALL be accepted (pending stays max, no overflow).
REQ-020 Pending SHALL never wrap; saturates at 2^PEND_W-1 and never goes below 0.
REQ-021 evt_in during ON or OFF (not at start) SHALL only increment pending; it never shortens/extends the current blink.
REQ-022 Timer width SHALL be clog2(max(ON_CYCLES,OFF_CYCLES)+1); no truncation at default values.
REQ-023 Every event accepted SHALL produce exactly one ON period; blinks separated by at least OFF_CYCLES low cycles.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, timer 0, pending 0, led_out 0, busy 0, overflow 0 next cycle.
REQ-025 rst mid-blink SHALL abort it and discard all pending events; evt_in during rst SHALL be ignored.
REQ-026 First cycle after rst deasserts SHALL accept evt_in per REQ-014.

Structure
REQ-027 Shared package blink_pkg SHALL hold the state enum (IDLE, ON, OFF) and default timing constants (ON_CYCLES/OFF_CYCLES defaults at 100 MHz).
REQ-028 One sub-module, blink_timer (loadable down-counter with expired flag, parameterized width), SHALL be used for the ON/OFF timing.
REQ-029 All outputs SHALL be registered; no combinational path from evt_in to any output.

Verification (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2)
REQ-030 Single pulse: evt_in at cycle 10 from IDLE -> led_out high cycles 11-14, low 15-17, busy low from 18, pending 0 throughout.
REQ-031 Burst: evt_in at cycles 10,11,12 -> pending 1 then 2, three blinks with led high 11-14, 18-21, 25-28, pending 0 after cycle 25.
REQ-032 Overflow: 5 back-to-back pulses at cycles 10-14 -> pending saturates at 3, 5th pulse (cycle 14) dropped, overflow high cycle 15 only, 4 blinks total.
REQ-033 Boundary: pending=3 and evt_in on OFF-expiry cycle -> pending stays 3, no overflow, next blink starts next cycle.
REQ-034 Reset mid-ON with pending=2: rst at cycle 12 -> cycle 13 led_out=0, pending=0, busy=0; evt_in at cycle 14 -> led high at 15.
REQ-035 Back-to-back events at OFF expiry with pending=0: evt_in on expiry cycle -> led high next cycle, no IDLE cycle.
